// File: rtl/kara_pkg.sv
// Shared widths, state encoding and partial-product types for the Karatsuba
// recombination stage.
package kara_pkg;

  localparam int HALF = 64;
  localparam int FULL = 2 * HALF;
  localparam int PROD = 4 * HALF;

  typedef enum logic [2:0] {
    IDLE,
    SUB0,
    SUB2,
    ADD_LO,
    ADD_HI,
    DONE
  } state_t;

  typedef logic [FULL+1:0] z1_t;

endpackage

// File: rtl/kara_combine_128.sv
// Karatsuba recombination: folds z0, z1, z2 into the 256-bit product by
// time-sharing the parent's 128-bit adder over four arithmetic cycles.
//   state  | meaning
//   IDLE   | waiting for a partial-product set
//   SUB0   | mid = z1 - z0
//   SUB2   | mid = mid - z2
//   ADD_LO | product[191:64] = z0 hi/z2 lo + mid, keep carry
//   ADD_HI | product[255:192] = z2 hi + mid bit 128 + carry, flag err
//   DONE   | product valid, wait for consumer
module kara_combine_128
  import kara_pkg::*;
#(
  parameter int HALF = kara_pkg::HALF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2*HALF-1:0]   z0,
  input  logic [2*HALF-1:0]   z2,
  input  logic [2*HALF+1:0]   z1,
  output logic [2*HALF-1:0]   add_a,
  output logic [2*HALF-1:0]   add_b,
  output logic                add_cin,
  input  logic [2*HALF-1:0]   add_sum,
  input  logic                add_cout,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*HALF-1:0]   product,
  output logic                err
);

  localparam int F = 2 * HALF;

  state_t          state, state_next;
  logic [F-1:0]    z0_q, z2_q;
  z1_t             z1_q;
  logic [F-1:0]    mid;
  logic [1:0]      mid_hi;
  logic            c;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Subtraction uses a + ~b + 1; mid_hi tracks the two bits above the adder.
  always_comb begin
    state_next = state;
    add_a      = '0;
    add_b      = '0;
    add_cin    = 1'b0;
    case (state)
      IDLE: if (in_valid) state_next = SUB0;
      SUB0: begin
        add_a      = z1_q[F-1:0];
        add_b      = ~z0_q;
        add_cin    = 1'b1;
        state_next = SUB2;
      end
      SUB2: begin
        add_a      = mid;
        add_b      = ~z2_q;
        add_cin    = 1'b1;
        state_next = ADD_LO;
      end
      ADD_LO: begin
        add_a      = {z2_q[HALF-1:0], z0_q[F-1:HALF]};
        add_b      = mid;
        state_next = ADD_HI;
      end
      ADD_HI: begin
        add_a      = {{HALF{1'b0}}, z2_q[F-1:HALF]};
        add_b      = {{(F-1){1'b0}}, mid_hi[0]};
        add_cin    = c;
        state_next = DONE;
      end
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      z0_q    <= '0;
      z1_q    <= '0;
      z2_q    <= '0;
      mid     <= '0;
      mid_hi  <= '0;
      c       <= 1'b0;
      product <= '0;
      err     <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: if (in_valid) begin
          z0_q <= z0;
          z1_q <= z1;
          z2_q <= z2;
        end
        SUB0: begin
          mid    <= add_sum;
          mid_hi <= z1_q[F+1:F] + 2'b11 + {1'b0, add_cout};
        end
        SUB2: begin
          mid    <= add_sum;
          mid_hi <= mid_hi + 2'b11 + {1'b0, add_cout};
        end
        ADD_LO: begin
          product[F+HALF-1:HALF] <= add_sum;
          product[HALF-1:0]      <= z0_q[HALF-1:0];
          c                      <= add_cout;
        end
        ADD_HI: begin
          product[4*HALF-1:F+HALF] <= add_sum[HALF-1:0];
          // Negative/oversized middle term, or a carry past bit 255.
          err <= mid_hi[1] | (|add_sum[F-1:HALF]);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_kara_combine_128.sv
// Self-checking bench for kara_combine_128; the parent's combinational adder
// is modelled here, results are checked against a*b and a wide-arithmetic model.
module tb_kara_combine_128;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] z0, z2;
  logic [129:0] z1;
  logic [127:0] add_a, add_b, add_sum;
  logic         add_cin, add_cout;
  logic         out_valid, out_ready;
  logic [255:0] product;
  logic         err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {128'd0, add_cin};

  kara_combine_128 dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .z0(z0), .z2(z2), .z1(z1),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .product(product), .err(err)
  );

  task automatic chk(input string tag, input logic [259:0] got, input logic [259:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // product = {z2,z0} + (z1 - z0 - z2) * 2^64, err when the middle term is out of range
  function automatic void model(input logic [127:0] m_z0, input logic [129:0] m_z1,
                                input logic [127:0] m_z2,
                                output logic [255:0] m_p, output logic m_e);
    logic [129:0] m;
    logic [257:0] full;
    m    = m_z1 - {2'b0, m_z0} - {2'b0, m_z2};
    full = {2'b0, m_z2, m_z0} + ({129'd0, m[128:0]} << 64);
    m_p  = full[255:0];
    m_e  = m[129] | (|full[257:256]);
  endfunction

  task automatic gen_valid(output logic [127:0] g_z0, output logic [129:0] g_z1,
                           output logic [127:0] g_z2, output logic [255:0] g_p);
    logic [127:0] a, b;
    logic [64:0]  sa, sb;
    a    = {$urandom, $urandom, $urandom, $urandom};
    b    = {$urandom, $urandom, $urandom, $urandom};
    g_z0 = {64'd0, a[63:0]} * {64'd0, b[63:0]};
    g_z2 = {64'd0, a[127:64]} * {64'd0, b[127:64]};
    sa   = {1'b0, a[63:0]} + {1'b0, a[127:64]};
    sb   = {1'b0, b[63:0]} + {1'b0, b[127:64]};
    g_z1 = {65'd0, sa} * {65'd0, sb};
    g_p  = {128'd0, a} * {128'd0, b};
  endtask

  // Called #1 after an edge with the DUT idle; returns #1 after the last edge.
  task automatic run_set(input string tag, input logic [127:0] s_z0, input logic [129:0] s_z1,
                         input logic [127:0] s_z2, input logic [255:0] ep, input logic ee,
                         input bit release_out);
    chk({tag, ":in_ready"}, {259'd0, in_ready}, 260'd1);
    z0 = s_z0; z1 = s_z1; z2 = s_z2;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk({tag, ":busy"}, {258'd0, in_ready, out_valid}, 260'd0);
      @(posedge clk); #1;
    end
    chk({tag, ":out_valid"}, {259'd0, out_valid}, 260'd1);
    chk({tag, ":product"}, {4'd0, product}, {4'd0, ep});
    chk({tag, ":err"}, {259'd0, err}, {259'd0, ee});
    if (release_out) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, ":back_idle"}, {258'd0, in_ready, out_valid}, 260'd2);
    end
  endtask

  initial begin
    logic [127:0] r_z0, r_z2;
    logic [129:0] r_z1;
    logic [255:0] r_p, m_p;
    logic         m_e;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    z0 = '0; z1 = '0; z2 = '0;
    #2;
    chk("reset_hs", {258'd0, in_ready, out_valid}, 260'd2);
    chk("reset_product", {4'd0, product}, 260'd0);
    chk("reset_err", {259'd0, err}, 260'd0);
    chk("reset_adder", {3'd0, add_a, add_b, add_cin}, 260'd0);
    #20 rst_n = 1'b1;
    @(posedge clk); #1;

    run_set("zero", 128'd0, 130'd0, 128'd0, 256'd0, 1'b0, 1'b1);
    run_set("3x5", 128'd15, 130'd15, 128'd0, 256'd15, 1'b0, 1'b1);
    run_set("2p64", 128'd0, 130'd1, 128'd1, 256'd1 << 128, 1'b0, 1'b1);
    r_z0 = {64'd0, 64'hFFFF_FFFF_FFFF_FFFF} * {64'd0, 64'hFFFF_FFFF_FFFF_FFFF};
    r_z1 = {65'd0, 65'h1_FFFF_FFFF_FFFF_FFFE} * {65'd0, 65'h1_FFFF_FFFF_FFFF_FFFE};
    run_set("max", r_z0, r_z1, r_z0,
            256'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE_0000_0000_0000_0000_0000_0000_0000_0001,
            1'b0, 1'b1);
    model(128'd1, 130'd0, 128'd0, m_p, m_e);
    run_set("neg_mid", 128'd1, 130'd0, 128'd0, m_p, 1'b1, 1'b1);

    for (int k = 0; k < 20; k++) begin
      gen_valid(r_z0, r_z1, r_z2, r_p);
      run_set("rand_valid", r_z0, r_z1, r_z2, r_p, 1'b0, 1'b1);
    end
    for (int k = 0; k < 10; k++) begin
      r_z0 = {$urandom, $urandom, $urandom, $urandom};
      r_z2 = {$urandom, $urandom, $urandom, $urandom};
      r_z1 = {2'($urandom), $urandom, $urandom, $urandom, $urandom};
      model(r_z0, r_z1, r_z2, m_p, m_e);
      run_set("rand_any", r_z0, r_z1, r_z2, m_p, m_e, 1'b1);
    end

    // Back-pressure: result must hold and new sets must be refused.
    gen_valid(r_z0, r_z1, r_z2, r_p);
    run_set("bp", r_z0, r_z1, r_z2, r_p, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      z0 = {$urandom, $urandom, $urandom, $urandom};
      z2 = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
      chk("bp_hold_hs", {258'd0, in_ready, out_valid}, 260'd1);
      chk("bp_hold_product", {4'd0, product}, {4'd0, r_p});
      chk("bp_hold_err", {259'd0, err}, 260'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_release_hs", {258'd0, in_ready, out_valid}, 260'd2);
    chk("bp_product_kept", {4'd0, product}, {4'd0, r_p});
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("bp_no_start", {258'd0, in_ready, out_valid}, 260'd2);
    end

    // Reset during SUB2 discards the operation.
    gen_valid(r_z0, r_z1, r_z2, r_p);
    z0 = r_z0; z1 = r_z1; z2 = r_z2;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_hs", {258'd0, in_ready, out_valid}, 260'd2);
    chk("rst_product", {4'd0, product}, 260'd0);
    chk("rst_err", {259'd0, err}, 260'd0);
    chk("rst_adder", {3'd0, add_a, add_b, add_cin}, 260'd0);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk("rst_no_output", {258'd0, in_ready, out_valid}, 260'd2);
    end
    gen_valid(r_z0, r_z1, r_z2, r_p);
    run_set("after_rst", r_z0, r_z1, r_z2, r_p, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
